// File: rtl/done_indicator_if.sv
// rtl/done_indicator_if.sv - done_indicator status bus: completion/clear inputs, verdict and LED outputs.
interface done_indicator_if #(
  parameter int CNT_W = 32
);
  logic             done_in;
  logic             clear;
  logic [3:0]       led;
  logic [1:0]       state;
  logic             pass;
  logic             fail;
  logic [CNT_W-1:0] cycles;

  // Driven side: the environment that raises done_in/clear and watches the verdict.
  modport master (
    output done_in,
    output clear,
    input  led,
    input  state,
    input  pass,
    input  fail,
    input  cycles
  );

  // Design side: the verdict logic itself.
  modport slave (
    input  done_in,
    input  clear,
    output led,
    output state,
    output pass,
    output fail,
    output cycles
  );
endinterface

// File: rtl/done_indicator.sv
// rtl/done_indicator.sv - RUN/PASS/FAIL completion verdict with cycle counter and LED heartbeat.
module done_indicator #(
  parameter int BLINK_HALF     = 50_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  done_indicator_if.slave  bus
);

  localparam int HB_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [HB_W-1:0]  HB_LAST      = HB_W'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [HB_W-1:0]  hb_q, hb_d;
  logic             phase_q, phase_d;
  logic [3:0]       led_q, led_d;
  logic             sync1_q, done_s;

  // done_in comes from another clock domain; clear deliberately leaves these flops alone
  // so a level held across clear is seen immediately afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      done_s  <= 1'b0;
    end else begin
      sync1_q <= bus.done_in;
      done_s  <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      cycles_q <= '0;
      hb_q     <= '0;
      phase_q  <= 1'b0;
      led_q    <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
      hb_q     <= hb_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    hb_d     = hb_q;
    phase_d  = phase_q;
    led_d    = 4'b0000;

    if (bus.clear) begin
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (done_s)
            state_d = ST_PASS;
          else if (cycles_q == TIMEOUT_LAST)
            state_d = ST_FAIL;
        end
        ST_PASS: state_d = ST_PASS;
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_RUN;
      endcase
    end

    // Count only on edges that stay in RUN, so the value is frozen on the exit edge.
    if (bus.clear) begin
      cycles_d = '0;
    end else if (state_q == ST_RUN && state_d == ST_RUN && cycles_q != '1) begin
      cycles_d = cycles_q + 1'b1;
    end

    if (bus.clear) begin
      hb_d    = '0;
      phase_d = 1'b0;
    end else if (hb_q == HB_LAST) begin
      hb_d    = '0;
      phase_d = ~phase_q;
    end else begin
      hb_d    = hb_q + 1'b1;
    end

    unique case (state_q)
      ST_RUN:  led_d = {3'b000, phase_q};
      ST_PASS: led_d = 4'b1111;
      ST_FAIL: led_d = phase_q ? 4'b1010 : 4'b0101;
      default: led_d = 4'b0000;
    endcase
  end

  assign bus.state  = state_q;
  assign bus.pass   = (state_q == ST_PASS);
  assign bus.fail   = (state_q == ST_FAIL);
  assign bus.cycles = cycles_q;
  assign bus.led    = led_q;

endmodule

// File: tb/tb_done_indicator.sv
// tb/tb_done_indicator.sv - directed self-checking bench for done_indicator.
module tb_done_indicator;

  localparam int BLINK_HALF     = 4;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int CNT_W          = 8;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  done_indicator_if #(.CNT_W(CNT_W)) dif ();

  done_indicator #(
    .BLINK_HALF    (BLINK_HALF),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    dif.done_in = 1'b0;
    dif.clear   = 1'b0;
    tick();
    reset_n     = 1'b1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b1;
    dif.done_in = 1'b0;
    dif.clear   = 1'b0;
    #1 reset_n  = 1'b0;
    #1;
    check("rst_led",    32'(dif.led),    32'h0);
    check("rst_state",  32'(dif.state),  32'h0);
    check("rst_pass",   32'(dif.pass),   32'h0);
    check("rst_fail",   32'(dif.fail),   32'h0);
    check("rst_cycles", 32'(dif.cycles), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Timeout path: heartbeat in RUN, FAIL at edge 20 with cycles frozen at 19.
    repeat (4) tick();
    check("run_led_e4", 32'(dif.led), 32'h0);
    tick();
    check("run_led_e5", 32'(dif.led), 32'h1);
    repeat (4) tick();
    check("run_led_e9", 32'(dif.led), 32'h0);
    repeat (10) tick();
    check("run_state_e19",  32'(dif.state),  32'h0);
    check("run_cycles_e19", 32'(dif.cycles), 32'd19);
    tick();
    check("to_state_e20",  32'(dif.state),  32'h2);
    check("to_fail_e20",   32'(dif.fail),   32'h1);
    check("to_pass_e20",   32'(dif.pass),   32'h0);
    check("to_cycles_e20", 32'(dif.cycles), 32'd19);
    check("to_led_e20",    32'(dif.led),    32'h0);
    tick();
    check("fail_led_e21", 32'(dif.led), 32'hA);
    repeat (4) tick();
    check("fail_led_e25",    32'(dif.led),    32'h5);
    check("fail_cycles_e25", 32'(dif.cycles), 32'd19);

    // FAIL is sticky against done; clear restarts counting and heartbeat.
    dif.done_in = 1'b1;
    repeat (4) tick();
    check("fail_sticky_state", 32'(dif.state), 32'h2);
    dif.done_in = 1'b0;
    repeat (3) tick();
    dif.clear = 1'b1;
    tick();
    check("clr_state",  32'(dif.state),  32'h0);
    check("clr_cycles", 32'(dif.cycles), 32'h0);
    check("clr_fail",   32'(dif.fail),   32'h0);
    dif.clear = 1'b0;
    tick();
    check("clr_led_c1",    32'(dif.led),    32'h0);
    check("clr_cycles_c1", 32'(dif.cycles), 32'd1);
    repeat (3) tick();
    check("clr_led_c4", 32'(dif.led), 32'h0);
    tick();
    check("clr_led_c5", 32'(dif.led), 32'h1);
    dif.done_in = 1'b1;
    repeat (2) tick();
    check("clr_state_c7",  32'(dif.state),  32'h0);
    check("clr_cycles_c7", 32'(dif.cycles), 32'd7);
    tick();
    check("clr_state_c8",  32'(dif.state),  32'h1);
    check("clr_pass_c8",   32'(dif.pass),   32'h1);
    check("clr_cycles_c8", 32'(dif.cycles), 32'd7);
    tick();
    check("clr_led_c9", 32'(dif.led), 32'hF);

    // Asynchronous reset between edges while in PASS.
    reset_n = 1'b0;
    #1;
    check("async_led",    32'(dif.led),    32'h0);
    check("async_pass",   32'(dif.pass),   32'h0);
    check("async_state",  32'(dif.state),  32'h0);
    check("async_cycles", 32'(dif.cycles), 32'h0);
    dif.done_in = 1'b0;
    tick();
    check("async_hold_cycles", 32'(dif.cycles), 32'h0);
    reset_n = 1'b1;

    // done_in sampled at edge 7 -> PASS at edge 9, LEDs solid at edge 10.
    tick();
    check("pass_cycles_e1", 32'(dif.cycles), 32'd1);
    repeat (5) tick();
    dif.done_in = 1'b1;
    repeat (2) tick();
    check("pass_state_e8", 32'(dif.state), 32'h0);
    tick();
    check("pass_pass_e9",   32'(dif.pass),   32'h1);
    check("pass_state_e9",  32'(dif.state),  32'h1);
    check("pass_cycles_e9", 32'(dif.cycles), 32'd8);
    check("pass_led_e9",    32'(dif.led),    32'h0);
    tick();
    check("pass_led_e10", 32'(dif.led), 32'hF);
    dif.done_in = 1'b0;
    repeat (5) tick();
    check("pass_sticky",        32'(dif.pass),   32'h1);
    check("pass_sticky_cycles", 32'(dif.cycles), 32'd8);

    // done_s rises exactly on the timeout edge: PASS wins.
    do_reset();
    repeat (17) tick();
    dif.done_in = 1'b1;
    repeat (2) tick();
    check("tie_state_e19",  32'(dif.state),  32'h0);
    check("tie_cycles_e19", 32'(dif.cycles), 32'd19);
    tick();
    check("tie_state_e20",  32'(dif.state),  32'h1);
    check("tie_fail_e20",   32'(dif.fail),   32'h0);
    check("tie_cycles_e20", 32'(dif.cycles), 32'd19);
    repeat (5) tick();
    check("tie_fail_later", 32'(dif.fail), 32'h0);

    // clear and done_s on the same edge: clear wins, PASS one edge later.
    do_reset();
    repeat (2) tick();
    dif.done_in = 1'b1;
    repeat (2) tick();
    check("cd_state_e4",  32'(dif.state),  32'h0);
    check("cd_cycles_e4", 32'(dif.cycles), 32'd4);
    dif.clear = 1'b1;
    tick();
    check("cd_state_e5",  32'(dif.state),  32'h0);
    check("cd_cycles_e5", 32'(dif.cycles), 32'h0);
    dif.clear = 1'b0;
    tick();
    check("cd_state_e6",  32'(dif.state),  32'h1);
    check("cd_cycles_e6", 32'(dif.cycles), 32'h0);
    tick();
    check("cd_led_e7", 32'(dif.led), 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/done_indicator.md
DONE_INDICATOR -- requirements
Module: done_indicator

Interface
REQ-001 Parameter BLINK_HALF, default 50_000_000: clock cycles per half-period of the LED heartbeat; legal range >=2.
REQ-002 Parameter TIMEOUT_CYCLES, default 100_000_000: RUN cycles allowed before a FAIL verdict; legal range >=2.
REQ-003 Parameter CNT_W, default 32: width of the cycle counter; 2^CNT_W must exceed TIMEOUT_CYCLES.
REQ-004 clk  input  1  system clock, 100 MHz board clock; all logic on its rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 done_in  input  1  processor completion flag from top; treated as asynchronous, level-sensitive.
REQ-007 clear  input  1  synchronous active-high restart of the verdict logic.
REQ-008 led  output  4  board LED drive, registered.
REQ-009 state  output  2  current verdict state: 00 RUN, 01 PASS, 10 FAIL; 11 never driven.
REQ-010 pass  output  1  high iff state==PASS.
REQ-011 fail  output  1  high iff state==FAIL.
REQ-012 cycles  output  CNT_W  RUN-cycle count, frozen on leaving RUN.

Function
REQ-013 done_in SHALL pass through a two-flop synchronizer; only the second flop (done_s) is used internally.
REQ-014 The FSM SHALL have states RUN, PASS, and FAIL; after reset or clear it SHALL be in RUN.
REQ-015 In RUN, cycles SHALL increment by 1 on every clock edge and saturate at all-ones, never wrapping.
REQ-016 RUN->PASS SHALL occur on the edge where done_s==1.
REQ-017 RUN->FAIL SHALL occur on the edge where done_s==0 and cycles==TIMEOUT_CYCLES-1.
REQ-018 If done_s==1 on the timeout edge, PASS SHALL win.
REQ-019 PASS and FAIL SHALL be sticky: done_s deasserting in PASS, or asserting in FAIL, changes nothing.
REQ-020 cycles SHALL hold its value on the transition edge out of RUN (it does not increment on that edge) and remain frozen until reset or clear.
REQ-021 Heartbeat counter SHALL count 0..BLINK_HALF-1, wrap to 0, and toggle phase bit on wrap; it SHALL run in every state.
REQ-022 led SHALL be registered from the current state and phase: RUN -> {3'b000, phase}; PASS -> 4'b1111; FAIL -> phase ? 4'b1010 : 4'b0101.
REQ-023 Latency: done_in sampled high at edge n -> done_s high after edge n+1 -> state/pass updated at edge n+2 -> led==4'b1111 at edge n+3.
REQ-024 clear SHALL have priority over every FSM transition on the same edge.
REQ-025 On clear, state SHALL return to RUN and cycles, the heartbeat counter and phase SHALL be zeroed; led follows on the next edge.
REQ-026 The synchronizer flops SHALL NOT be affected by clear.
REQ-027 done_in held high across clear SHALL re-enter PASS on the edge after clear deasserts.

Reset
REQ-028 While reset_n==0, all flops SHALL be forced immediately, without waiting for clk: state=RUN, cycles=0, heartbeat counter=0, phase=0, synchronizer=0, led=4'b0000, pass=0, fail=0.
REQ-029 Reset release SHALL take effect on the first rising clk edge with reset_n==1.
REQ-030 Reset asserted mid-operation in any state SHALL produce the REQ-028 values within the same cycle.

Verification (BLINK_HALF=4, TIMEOUT_CYCLES=20)
REQ-031 Reset, done_in=0: led[0] toggles every 4 cycles, led[3:1]=0, state=00 -> at cycle 20 state=10, cycles=19, and led alternates 0101/1010 every 4 cycles.
REQ-032 done_in asserted at edge 7: pass=1 at edge 9, led=1111 at edge 10, cycles=8; done_in dropped later -> PASS holds.
REQ-033 done_in asserted so that done_s==1 exactly on the timeout edge -> state=01, fail never asserts.
REQ-034 In FAIL, done_in asserted -> state stays 10; pulse clear for 1 cycle -> state=00, cycles=0, heartbeat restarts from phase 0, then PASS at sync latency.
REQ-035 reset_n pulled low between clock edges while in PASS -> led=0000, pass=0, state=00 before the next edge; counting resumes from 0 after release.
REQ-036 Assert clear and done_s on the same edge -> state=00 after that edge, PASS on the following edge if done_in is still high.
